cordic_vectoring: RTL

Iterative vectoring-mode CORDIC that converts a Cartesian vector (x, y) in signed Q16.16 into magnitude and angle (atan2). It is the inverse of the pipelined rotation-mode CORDIC, which maps (x0, y0, z0) to rotated (X, Y). Its angle output uses the same Q16.16-radian format as that core's z0 input, so the two can be chained for round-trip checks. One shared datapath runs for ITERATIONS cycles per transaction, with valid/ready handshakes on both sides.

---
 rtl/cordic_vectoring.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: Q16.16 (x, y) -> magnitude and atan2 angle; CORDIC_VECT_GAIN_COMP_EN adds a 1/K scale cycle.
// Result after ITERATIONS edges (+1 when scaling); one transaction at a time, result held in DONE until out_ready.
module cordic_vectoring #(
  parameter int ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mag,
  output logic [31:0] angle
);

  localparam logic signed [31:0] HALF_PI = 32'sd102944;
  localparam logic [4:0]         LAST    = 5'(ITERATIONS - 1);

`ifdef CORDIC_VECT_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;
  localparam logic [16:0] KINV = 17'd39797;
  logic signed [50:0] prod;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  state_t             state, state_nxt;
  logic [4:0]         cnt;
  logic signed [33:0] x_r, y_r;
  logic signed [31:0] z_r;
  logic               zero_r;

  logic signed [33:0] x_ext, y_ext, x_pre, y_pre, x_sh, y_sh, x_nxt, y_nxt;
  logic signed [31:0] z_pre, z_nxt;

  function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 32'sd51472;
      5'd1:    atan_lut = 32'sd30386;
      5'd2:    atan_lut = 32'sd16055;
      5'd3:    atan_lut = 32'sd8150;
      5'd4:    atan_lut = 32'sd4091;
      5'd5:    atan_lut = 32'sd2047;
      5'd6:    atan_lut = 32'sd1024;
      5'd7:    atan_lut = 32'sd512;
      5'd8:    atan_lut = 32'sd256;
      5'd9:    atan_lut = 32'sd128;
      5'd10:   atan_lut = 32'sd64;
      5'd11:   atan_lut = 32'sd32;
      5'd12:   atan_lut = 32'sd16;
      5'd13:   atan_lut = 32'sd8;
      5'd14:   atan_lut = 32'sd4;
      5'd15:   atan_lut = 32'sd2;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  function automatic logic [31:0] sat32(input logic signed [34:0] v);
    if (v > 35'sd2147483647) sat32 = 32'h7FFF_FFFF;
    else                     sat32 = v[31:0];
  endfunction

  assign x_ext     = {{2{x_in[31]}}, x_in};
  assign y_ext     = {{2{y_in[31]}}, y_in};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Fold the left half-plane onto the right one; y = 0 on the negative axis goes to +pi.
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_ext[33]) begin
      if (!y_ext[33]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = HALF_PI;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -HALF_PI;
      end
    end
  end

  always_comb begin
    x_sh = x_r >>> cnt;
    y_sh = y_r >>> cnt;
    if (!y_r[33]) begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = z_r + atan_lut(cnt);
    end else begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = z_r - atan_lut(cnt);
    end
  end

`ifdef CORDIC_VECT_GAIN_COMP_EN
  // Low 51 bits of the product do not depend on operand signedness.
  assign prod = {{17{x_r[33]}}, x_r} * {34'd0, KINV};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = ITER;
`ifdef CORDIC_VECT_GAIN_COMP_EN
      ITER:  if (cnt == LAST) state_nxt = SCALE;
      SCALE: state_nxt = DONE;
`else
      ITER:  if (cnt == LAST) state_nxt = DONE;
`endif
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      zero_r <= 1'b0;
      mag    <= '0;
      angle  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x_pre;
            y_r    <= y_pre;
            z_r    <= z_pre;
            cnt    <= '0;
            zero_r <= (x_in == 32'd0) && (y_in == 32'd0);
          end
        end
        ITER: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            // A zero vector never steers y, so z would sum the whole table.
            angle <= zero_r ? 32'd0 : z_nxt;
`ifndef CORDIC_VECT_GAIN_COMP_EN
            mag   <= sat32({x_nxt[33], x_nxt});
`endif
          end
        end
`ifdef CORDIC_VECT_GAIN_COMP_EN
        SCALE: mag <= sat32(prod[50:16]);
`endif
        default: ;
      endcase
    end
  end

endmodule
